// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl: sequencer/monitor for the three phase-edge debouncers.
// Produces the shared enable tick, tracks phase rotation and edge order,
// measures the A-phase period in ticks and reports lock/fault status.
module phase_seq_ctrl #(
    parameter int unsigned DIV        = 500,
    parameter int unsigned PERW       = 12,
    parameter int unsigned LOCK_EDGES = 3
) (
    input  logic            clk,
    input  logic            rst,
    output logic            tick,
    input  logic [2:0]      dbphase,
    input  logic [2:0]      missing,
    output logic            locked,
    output logic            rotation,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [PERW-1:0] period,
    output logic            period_valid
);

    localparam int unsigned PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned GW  = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_MISS = 2'b01;
    localparam logic [1:0] CODE_SEQ  = 2'b10;
    localparam logic [1:0] CODE_OVF  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_TRACK,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [PSW-1:0]  presc_q;
    logic            tick_q;
    logic [PERW-1:0] pcnt_q, pcnt_d;
    logic [GW-1:0]   good_q, good_d;
    logic [2:0]      last_q, last_d;     // one-hot phase of the last accepted edge
    logic            rot_q, rot_d;
    logic            locked_q, locked_d;
    logic            fault_q, fault_d;
    logic [1:0]      code_q, code_d;
    logic [PERW-1:0] period_q, period_d;
    logic            pv_q, pv_d;

    logic            multi;
    logic            single;
    logic            a_edge;
    logic            pcnt_sat;
    logic [2:0]      exp_edge;
    logic            go_fault;
    logic [1:0]      cause;

    assign multi    = (dbphase & (dbphase - 3'd1)) != 3'b000;
    assign single   = (dbphase != 3'b000) && !multi;
    assign a_edge   = (dbphase == 3'b001);
    assign pcnt_sat = (pcnt_q == '1);
    // A->B->C is a left rotation of the one-hot phase, A->C->B a right rotation.
    assign exp_edge = rot_q ? {last_q[0], last_q[2:1]} : {last_q[1:0], last_q[2]};

    // Prescaler: one-clk tick every DIV clocks, registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (presc_q == PSW'(DIV - 1)) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
            tick_q  <= 1'b0;
        end
    end

    // Sequencer state and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pcnt_q   <= '0;
            good_q   <= '0;
            last_q   <= 3'b001;
            rot_q    <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= CODE_NONE;
            period_q <= '0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            good_q   <= good_d;
            last_q   <= last_d;
            rot_q    <= rot_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            period_q <= period_d;
            pv_q     <= pv_d;
        end
    end

    // Next-state logic: edge checking, lock counting, period capture, faults.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        last_d   = last_q;
        rot_d    = rot_q;
        locked_d = locked_q;
        fault_d  = fault_q;
        code_d   = code_q;
        period_d = period_q;
        pv_d     = 1'b0;
        go_fault = 1'b0;
        cause    = CODE_NONE;

        // An A edge always restarts the period count, even on a tick.
        if (a_edge) begin
            pcnt_d = '0;
        end else if (tick_q && !pcnt_sat) begin
            pcnt_d = pcnt_q + 1'b1;
        end else begin
            pcnt_d = pcnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (a_edge) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (multi) begin
                    go_fault = 1'b1;
                    cause    = CODE_SEQ;
                end else if (dbphase == 3'b010) begin
                    rot_d   = 1'b0;
                    last_d  = 3'b010;
                    good_d  = '0;
                    state_d = S_TRACK;
                end else if (dbphase == 3'b100) begin
                    rot_d   = 1'b1;
                    last_d  = 3'b100;
                    good_d  = '0;
                    state_d = S_TRACK;
                end
            end
            S_TRACK, S_LOCKED: begin
                if (missing != 3'b000) begin
                    go_fault = 1'b1;
                    cause    = CODE_MISS;
                end else if (multi || (single && (dbphase != exp_edge))) begin
                    go_fault = 1'b1;
                    cause    = CODE_SEQ;
                end else if (pcnt_sat) begin
                    go_fault = 1'b1;
                    cause    = CODE_OVF;
                end else if (single) begin
                    last_d = dbphase;
                    if (a_edge) begin
                        period_d = pcnt_q;
                        pv_d     = 1'b1;
                    end
                    if (state_q == S_TRACK) begin
                        if (good_q == GW'(LOCK_EDGES - 1)) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                end
            end
            S_FAULT: begin
                if ((missing == 3'b000) && a_edge) begin
                    state_d = S_SYNC;
                    fault_d = 1'b0;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_fault) begin
            state_d  = S_FAULT;
            fault_d  = 1'b1;
            code_d   = cause;
            locked_d = 1'b0;
            good_d   = '0;
        end
    end

    assign tick         = tick_q;
    assign locked       = locked_q;
    assign rotation     = rot_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
    assign period       = period_q;
    assign period_valid = pv_q;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// tb_phase_seq_ctrl: randomized and directed checks of phase_seq_ctrl against
// a behavioural model built from cycle counts and phase-order positions.
module tb_phase_seq_ctrl;

    localparam int unsigned DIV        = 5;
    localparam int unsigned PERW       = 8;
    localparam int unsigned LOCK_EDGES = 3;
    localparam int          PMAX       = (1 << PERW) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_TRACK  = 2;
    localparam int M_LOCKED = 3;
    localparam int M_FAULT  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      dbphase = 3'b000;
    logic [2:0]      missing = 3'b000;
    logic            tick;
    logic            locked;
    logic            rotation;
    logic            fault;
    logic [1:0]      fault_code;
    logic [PERW-1:0] period;
    logic            period_valid;

    always #5 clk = ~clk;

    phase_seq_ctrl #(
        .DIV        (DIV),
        .PERW       (PERW),
        .LOCK_EDGES (LOCK_EDGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .dbphase      (dbphase),
        .missing      (missing),
        .locked       (locked),
        .rotation     (rotation),
        .fault        (fault),
        .fault_code   (fault_code),
        .period       (period),
        .period_valid (period_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int              m_cyc;
    int              m_pcnt;
    int              m_mode;
    int              m_pos;
    int              m_good;
    logic            m_tick;
    logic            m_rot;
    logic            m_locked;
    logic            m_fault;
    logic [1:0]      m_code;
    logic [PERW-1:0] m_period;
    logic            m_pv;

    // Running record of cycles where the DUT disagreed with the model.
    int              mism = 0;
    logic [PERW+6:0] mism_got;
    logic [PERW+6:0] mism_exp;

    // Phase index at position p of the rotation order (0=A,1=B,2=C).
    function automatic int seq_at(input int rot, input int p);
        if (rot == 0) return p % 3;
        return (3 - (p % 3)) % 3;
    endfunction

    function automatic int pos_of(input int rot, input int idx);
        if (rot == 0) return idx;
        return (3 - idx) % 3;
    endfunction

    function automatic logic [2:0] phase_bit(input int idx);
        logic [2:0] one;
        one = 3'b001;
        return one << idx;
    endfunction

    function automatic logic [PERW+6:0] dut_vec();
        return {tick, locked, rotation, fault, fault_code, period, period_valid};
    endfunction

    function automatic logic [PERW+6:0] mdl_vec();
        return {m_tick, m_locked, m_rot, m_fault, m_code, m_period, m_pv};
    endfunction

    task automatic model_step(input logic r, input logic [2:0] ph, input logic [2:0] ms);
        logic prev_tick;
        int   prev_pcnt;
        int   nbits;
        int   idx;
        int   cause;
        if (r) begin
            m_cyc = 0; m_pcnt = 0; m_mode = M_IDLE; m_pos = 0; m_good = 0;
            m_tick = 0; m_rot = 0; m_locked = 0; m_fault = 0; m_code = 2'd0;
            m_period = '0; m_pv = 0;
            return;
        end
        prev_tick = m_tick;
        prev_pcnt = m_pcnt;
        m_cyc     = m_cyc + 1;
        m_tick    = ((m_cyc % DIV) == 0);
        m_pv      = 1'b0;
        nbits     = $countones(ph);
        idx       = ph[1] ? 1 : (ph[2] ? 2 : 0);
        cause     = 0;
        if (ph == 3'b001) m_pcnt = 0;
        else if (prev_tick && m_pcnt < PMAX) m_pcnt = m_pcnt + 1;

        if (m_mode == M_IDLE) begin
            if (ph == 3'b001) m_mode = M_SYNC;
        end else if (m_mode == M_SYNC) begin
            if (nbits > 1) cause = 2;
            else if (nbits == 1 && idx != 0) begin
                m_rot  = (idx == 2);
                m_pos  = pos_of(int'(m_rot), idx);
                m_good = 0;
                m_mode = M_TRACK;
            end
        end else if (m_mode == M_TRACK || m_mode == M_LOCKED) begin
            if (ms != 3'b000) cause = 1;
            else if (nbits > 1 || (nbits == 1 && idx != seq_at(int'(m_rot), m_pos + 1))) cause = 2;
            else if (prev_pcnt == PMAX) cause = 3;
            else if (nbits == 1) begin
                m_pos = (m_pos + 1) % 3;
                if (idx == 0) begin
                    m_period = PERW'(prev_pcnt);
                    m_pv     = 1'b1;
                end
                if (m_mode == M_TRACK) begin
                    if (m_good == int'(LOCK_EDGES) - 1) begin
                        m_mode   = M_LOCKED;
                        m_locked = 1'b1;
                    end else begin
                        m_good = m_good + 1;
                    end
                end
            end
        end else begin
            if (ms == 3'b000 && ph == 3'b001) begin
                m_mode  = M_SYNC;
                m_fault = 1'b0;
                m_code  = 2'd0;
            end
        end

        if (cause != 0) begin
            m_mode   = M_FAULT;
            m_fault  = 1'b1;
            m_code   = 2'(cause);
            m_locked = 1'b0;
            m_good   = 0;
        end
    endtask

    // Apply one clock of inputs, advance the model, sample 1 time unit later.
    task automatic drive_cycle(input logic r, input logic [2:0] ph, input logic [2:0] ms);
        rst     = r;
        dbphase = ph;
        missing = ms;
        @(posedge clk);
        model_step(r, ph, ms);
        #1;
        if (dut_vec() !== mdl_vec()) begin
            mism     = mism + 1;
            mism_got = dut_vec();
            mism_exp = mdl_vec();
        end
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 3'b000, 3'b000);
        drive_cycle(1'b1, 3'b000, 3'b000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'b000, 3'b000);
    endtask

    // Drive n edges of the given rotation, G ticks apart, off the tick phase.
    task automatic run_edges(input int rot, input int n, input int g,
                             output int lock_at, output int pv_cnt);
        lock_at = 0;
        pv_cnt  = 0;
        while ((m_cyc % DIV) != 2) drive_cycle(1'b0, 3'b000, 3'b000);
        for (int k = 0; k < n; k++) begin
            drive_cycle(1'b0, phase_bit(seq_at(rot, k)), 3'b000);
            if (period_valid) pv_cnt++;
            if (locked && lock_at == 0) lock_at = k + 1;
            if (k < n - 1) begin
                for (int c = 0; c < g * int'(DIV) - 1; c++) begin
                    drive_cycle(1'b0, 3'b000, 3'b000);
                    if (period_valid) pv_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        int m0;
        m0 = mism;
        do_reset();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", dut_vec());
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL reset_model: got %h expected %h", mism_got, mism_exp);
        end
    endtask

    task automatic test_tick();
        int m0;
        int bad;
        int ticks;
        m0    = mism;
        bad   = 0;
        ticks = 0;
        do_reset();
        for (int k = 1; k <= 3 * int'(DIV) + 2; k++) begin
            drive_cycle(1'b0, 3'b000, 3'b000);
            if (tick) ticks++;
            if (tick !== ((k % DIV) == 0)) bad++;
        end
        n_checks++;
        if (bad != 0 || ticks != 3) begin
            n_fail++;
            $display("FAIL tick_timing: got %0d ticks %0d misplaced, expected 3 ticks 0 misplaced", ticks, bad);
        end
        n_checks++;
        if ({locked, fault, fault_code, period, period_valid} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected 0", dut_vec());
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL tick_model: got %h expected %h", mism_got, mism_exp);
        end
    endtask

    task automatic test_rotation(input int rot);
        int m0, g, lock_at, pv_cnt;
        m0 = mism;
        g  = int'($urandom_range(3, 8));
        do_reset();
        run_edges(rot, 10, g, lock_at, pv_cnt);
        n_checks++;
        if (rotation !== rot[0] || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation_%0d: got rot=%b locked=%b expected rot=%0d locked=1", rot, rotation, locked, rot);
        end
        n_checks++;
        if (lock_at != 5) begin
            n_fail++;
            $display("FAIL lock_edge_%0d: got %0d expected 5", rot, lock_at);
        end
        n_checks++;
        if (int'(period) != 3 * g) begin
            n_fail++;
            $display("FAIL period_%0d: got %0d expected %0d", rot, period, 3 * g);
        end
        n_checks++;
        if (pv_cnt != 3) begin
            n_fail++;
            $display("FAIL period_valid_%0d: got %0d pulses expected 3", rot, pv_cnt);
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL rotation_model_%0d: got %h expected %h", rot, mism_got, mism_exp);
        end
    endtask

    task automatic test_bad_seq();
        int m0, g, lock_at, pv_cnt;
        logic [PERW-1:0] per0;
        m0 = mism;
        g  = int'($urandom_range(3, 6));
        do_reset();
        run_edges(0, 7, g, lock_at, pv_cnt);
        per0 = period;
        idle(g * int'(DIV) - 1);
        drive_cycle(1'b0, 3'b001, 3'b000);
        n_checks++;
        if ({fault, fault_code, locked, period_valid} !== 5'b1_10_0_0 || period !== per0) begin
            n_fail++;
            $display("FAIL bad_sequence: got f=%b code=%b lk=%b pv=%b per=%0d expected f=1 code=10 lk=0 pv=0 per=%0d",
                     fault, fault_code, locked, period_valid, period, per0);
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL bad_seq_model: got %h expected %h", mism_got, mism_exp);
        end
    endtask

    task automatic test_missing();
        int m0, lock_at, pv_cnt;
        m0 = mism;
        do_reset();
        run_edges(0, 6, 3, lock_at, pv_cnt);
        drive_cycle(1'b0, 3'b000, 3'b010);
        idle(4);
        n_checks++;
        if ({fault, fault_code, locked} !== 4'b1_01_0) begin
            n_fail++;
            $display("FAIL missing_fault: got f=%b code=%b lk=%b expected f=1 code=01 lk=0", fault, fault_code, locked);
        end
        drive_cycle(1'b0, 3'b001, 3'b000);
        n_checks++;
        if ({fault, fault_code} !== 3'b0_00) begin
            n_fail++;
            $display("FAIL fault_recover: got f=%b code=%b expected f=0 code=00", fault, fault_code);
        end
        idle(7);
        drive_cycle(1'b0, 3'b010, 3'b000);
        idle(7);
        // In TRACK after A,B the expected edge is C, so a second A is a sequence error.
        drive_cycle(1'b0, 3'b001, 3'b000);
        n_checks++;
        if ({fault, fault_code} !== 3'b1_10) begin
            n_fail++;
            $display("FAIL resync_track: got f=%b code=%b expected f=1 code=10", fault, fault_code);
        end
        // Missing and a wrong edge together: missing wins.
        do_reset();
        run_edges(0, 2, 3, lock_at, pv_cnt);
        drive_cycle(1'b0, 3'b001, 3'b001);
        n_checks++;
        if (fault_code !== 2'b01) begin
            n_fail++;
            $display("FAIL missing_priority: got %b expected 01", fault_code);
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL missing_model: got %h expected %h", mism_got, mism_exp);
        end
    endtask

    task automatic test_overflow();
        int m0, lock_at, pv_cnt, waited;
        logic [PERW-1:0] per0;
        m0 = mism;
        do_reset();
        run_edges(0, 5, 3, lock_at, pv_cnt);
        per0   = period;
        waited = 0;
        while (!fault && waited < 4 * PMAX * int'(DIV)) begin
            drive_cycle(1'b0, 3'b000, 3'b000);
            waited++;
        end
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'b11 || period !== per0) begin
            n_fail++;
            $display("FAIL overflow: got f=%b code=%b per=%0d after %0d clks expected f=1 code=11 per=%0d",
                     fault, fault_code, period, waited, per0);
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL overflow_model: got %h expected %h", mism_got, mism_exp);
        end
    endtask

    task automatic test_multi();
        int m0, lock_at, pv_cnt;
        m0 = mism;
        do_reset();
        drive_cycle(1'b0, 3'b011, 3'b000);
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_idle: got f=%b expected 0", fault);
        end
        run_edges(0, 2, 3, lock_at, pv_cnt);
        drive_cycle(1'b0, 3'b011, 3'b000);
        n_checks++;
        if ({fault, fault_code} !== 3'b1_10) begin
            n_fail++;
            $display("FAIL multi_track: got f=%b code=%b expected f=1 code=10", fault, fault_code);
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL multi_model: got %h expected %h", mism_got, mism_exp);
        end
    endtask

    task automatic test_rst_mid();
        int lock_at, pv_cnt;
        do_reset();
        run_edges(1, 7, 3, lock_at, pv_cnt);
        drive_cycle(1'b1, 3'b000, 3'b000);
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_locked: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_random();
        int m0, p;
        logic [2:0] ph, ms;
        m0 = mism;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            p  = int'($urandom_range(0, 99));
            ms = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (p < 85) ph = 3'b000;
            else if (p < 95) ph = (m_mode == M_TRACK || m_mode == M_LOCKED)
                                  ? phase_bit(seq_at(int'(m_rot), m_pos + 1)) : 3'b001;
            else if (p < 98) ph = phase_bit(int'($urandom_range(0, 2)));
            else ph = 3'($urandom_range(0, 7));
            drive_cycle($urandom_range(0, 999) == 0, ph, ms);
        end
        n_checks++;
        if (mism != m0) begin
            n_fail++;
            $display("FAIL random_model: %0d cycles differ, last got %h expected %h", mism - m0, mism_got, mism_exp);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_rotation(0);
        test_rotation(1);
        test_bad_seq();
        test_missing();
        test_overflow();
        test_multi();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
